uno_seq: RTL and testbench
==========================

// Module: uno_seq
// PURPOSE
//  Upstream sequencer for one pe_m_6 PE in unary mode. Evaluates a polynomial
//  approximation by Horner's rule: acc = acc*x + c_k, for k = 0..NUM_TERMS-1.
//  Modes are div (01), exp (10) and log (11).
//  Drives the PE's gemm_uno, var_i, wc_i and mac_i, and feeds the PE's o_o back
//  into mac_i so the PE completes one Horner step per cycle. Coefficients come
//  from a per-op register table written over a config port.
// PARAMETERS
//  MUL_BW     16  operand/coefficient width; matches the PE
//  ACC_BW     32  accumulator width; matches the PE
//  NUM_TERMS   4  coefficients per op; must be >= 2
//  IDX_BW      2  $clog2(NUM_TERMS)
// PORTS
//  clk         in   1        clock
//  rst         in   1        asynchronous reset, active-high
//  cfg_we      in   1        coefficient write strobe
//  cfg_op      in   2        target op (01/10/11); 00 is ignored
//  cfg_idx     in   IDX_BW   coefficient index
//  cfg_data    in   MUL_BW   signed coefficient
//  in_valid    in   1        request valid
//  in_ready    out  1        request ready
//  in_op       in   2        requested op
//  in_x        in   MUL_BW   signed operand x
//  out_valid   out  1        result valid
//  out_ready   in   1        result accepted
//  out_data    out  ACC_BW   signed result
//  out_err     out  1        request had op 00
//  pe_gemm_uno out  2        to PE gemm_uno
//  pe_var      out  MUL_BW   to PE var_i
//  pe_wc       out  MUL_BW   to PE wc_i
//  pe_mac      out  ACC_BW   to PE mac_i
//  pe_o        in   ACC_BW   from PE o_o
// BEHAVIOUR
//  Reset: FSM goes to IDLE; every output is 0; all coefficient entries are 0.
//   Reset mid-op aborts the op with no result and no handshake.
//  FSM states: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
//  - in_ready = (state == IDLE). The request is accepted on the edge where
//    in_valid && in_ready; that cycle is cycle 0.
//  - Op 00 accepted: go straight to DONE. out_data = 0, out_err = 1.
//  - Uno op accepted: latch op and x. pe_gemm_uno = op from cycle 1 until the
//    return to IDLE, then holds its last value.
//  - RUN, cycles 1..N (N = NUM_TERMS): pe_var = x; pe_wc = c[op][k] in cycle k+1.
//  - pe_mac = 0 in cycle 2 (seed). pe_mac = pe_o (combinational feedback) in
//    cycles 3..N+1. pe_mac = 0 at all other times.
//  - DRAIN, cycles N+1..N+2: pe_wc = 0 and pe_var holds x.
//  - Capture: out_data <= pe_o at the end of cycle N+2. out_valid = 1 from
//    cycle N+3. Latency N+3 cycles (7 for N=4).
//  - DONE: out_valid, out_data and out_err hold until out_valid && out_ready.
//    Leave DONE on that edge; out_valid drops the next cycle. in_ready rises
//    the cycle after leaving DONE, so there is no back-to-back accept.
//  - out_err clears when a uno result is captured.
//  - cfg writes take effect only in IDLE. They are dropped in other states.
//  - In IDLE, a cfg write coinciding with an accept lands before the op's
//    first read.
//  - The PE saturates and truncates pe_mac itself. pe_o is fed back unmodified.
//  - Arithmetic is two's complement and sign-preserving; the sequencer does no
//    rescaling.
// STRUCTURE
//  - Package uno_pkg: op encodings (OP_GEMM, OP_DIV, OP_EXP, OP_LOG); state
//    enum; type coef_t = logic signed [MUL_BW-1:0].
//  - Sub-module uno_coef_rf: 3 x NUM_TERMS register file. One sync write port,
//    one combinational read port, async active-high reset.
//  - Top: FSM, step counter (IDX_BW+1 bits), operand/op latches, output
//    register, pe_mac mux.
// TESTING (N=4; bench drives pe_o with scripted values)
//  1. Write exp coefficients {3,-2,5,7}; request op=10, x=16'sd4 ->
//     pe_wc = 3,-2,5,7 in cycles 1..4; pe_var = 4 in cycles 1..6;
//     pe_gemm_uno = 2'b10 from cycle 1.
//  2. Same run with pe_o = 32'h00001234 in cycle 6 -> out_valid in cycle 7,
//     out_data = 32'h00001234, out_err = 0; pe_mac = 0 in cycle 2;
//     pe_mac follows pe_o in cycles 3..5.
//  3. Hold out_ready = 0 for 5 cycles after out_valid -> out_data is stable,
//     in_ready = 0 throughout; one cycle after the out_ready pulse,
//     in_ready = 1.
//  4. Request op=00 -> out_valid in cycle 1, out_data = 0, out_err = 1;
//     pe_wc and pe_mac stay 0.
//  5. cfg_we to div idx 0 during RUN of a div op -> dropped: the next div op
//    still issues the old c[0].
//  6. Assert rst in cycle 3 of a run -> all outputs 0 immediately; in_ready = 1
//    after release; coefficient table is 0, so pe_wc = 0 on the next op.

Source files
------------

// File: rtl/uno_pkg.sv
// Shared definitions for the unary-mode Horner sequencer: op encodings,
// sequencer states and the default widths of the PE datapath.
package uno_pkg;

    localparam int DEF_MUL_BW    = 16;
    localparam int DEF_ACC_BW    = 32;
    localparam int DEF_NUM_TERMS = 4;
    localparam int DEF_IDX_BW    = 2;

    localparam logic [1:0] OP_GEMM = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_EXP  = 2'b10;
    localparam logic [1:0] OP_LOG  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef logic signed [DEF_MUL_BW-1:0] coef_t;

endpackage

// File: rtl/uno_coef_rf.sv
// Coefficient table: one row of NUM_TERMS coefficients per unary op.
// Op 00 has no row; writes to it are ignored and reads of it return 0.
module uno_coef_rf
    import uno_pkg::*;
#(
    parameter int MUL_BW    = DEF_MUL_BW,
    parameter int NUM_TERMS = DEF_NUM_TERMS,
    parameter int IDX_BW    = DEF_IDX_BW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [1:0]        wr_op,
    input  logic [IDX_BW-1:0] wr_idx,
    input  logic [MUL_BW-1:0] wr_data,
    input  logic [1:0]        rd_op,
    input  logic [IDX_BW-1:0] rd_idx,
    output logic [MUL_BW-1:0] rd_data
);

    logic [MUL_BW-1:0] mem [3][NUM_TERMS];
    logic [1:0]        wr_row;
    logic [1:0]        rd_row;

    assign wr_row = wr_op - 2'd1;
    assign rd_row = rd_op - 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int i = 0; i < NUM_TERMS; i++) begin
                    mem[r][i] <= '0;
                end
            end
        end else if (we && wr_op != OP_GEMM && 32'(wr_idx) < NUM_TERMS) begin
            mem[wr_row][wr_idx] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_op != OP_GEMM && 32'(rd_idx) < NUM_TERMS) begin
            rd_data = mem[rd_row][rd_idx];
        end
    end

endmodule

// File: rtl/uno_seq.sv
// Upstream sequencer that walks one PE through a Horner polynomial, one step
// per cycle, by feeding the PE's output straight back into its MAC input.
module uno_seq
    import uno_pkg::*;
#(
    parameter int MUL_BW    = DEF_MUL_BW,
    parameter int ACC_BW    = DEF_ACC_BW,
    parameter int NUM_TERMS = DEF_NUM_TERMS,
    parameter int IDX_BW    = DEF_IDX_BW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_op,
    input  logic [IDX_BW-1:0] cfg_idx,
    input  logic [MUL_BW-1:0] cfg_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [MUL_BW-1:0] in_x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_BW-1:0] out_data,
    output logic              out_err,
    output logic [1:0]        pe_gemm_uno,
    output logic [MUL_BW-1:0] pe_var,
    output logic [MUL_BW-1:0] pe_wc,
    output logic [ACC_BW-1:0] pe_mac,
    input  logic [ACC_BW-1:0] pe_o
);

    localparam int CNT_BW = IDX_BW + 1;
    // step counts cycles since accept minus one: cycle k of an op has step k-1.
    localparam logic [CNT_BW-1:0] RUN_LAST   = CNT_BW'(NUM_TERMS - 1);
    localparam logic [CNT_BW-1:0] DRAIN_LAST = CNT_BW'(NUM_TERMS + 1);
    localparam logic [CNT_BW-1:0] FB_FIRST   = CNT_BW'(2);
    localparam logic [CNT_BW-1:0] FB_LAST    = CNT_BW'(NUM_TERMS);

    state_t            state;
    state_t            state_nx;
    logic [CNT_BW-1:0] step;
    logic [1:0]        op_q;
    logic [MUL_BW-1:0] x_q;
    logic [MUL_BW-1:0] coef_rd;
    logic              accept;
    logic              busy;
    logic              cfg_wr_en;

    // Handshakes: a request transfers on a rising edge where in_valid && in_ready,
    // a result on one where out_valid && out_ready; neither side may retract
    // its valid, and the sequencer never offers both at once.
    assign accept    = in_valid && in_ready;
    assign cfg_wr_en = cfg_we && (state == ST_IDLE);

    uno_coef_rf #(
        .MUL_BW   (MUL_BW),
        .NUM_TERMS(NUM_TERMS),
        .IDX_BW   (IDX_BW)
    ) u_coef_rf (
        .clk    (clk),
        .rst    (rst),
        .we     (cfg_wr_en),
        .wr_op  (cfg_op),
        .wr_idx (cfg_idx),
        .wr_data(cfg_data),
        .rd_op  (op_q),
        .rd_idx (step[IDX_BW-1:0]),
        .rd_data(coef_rd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (accept) state_nx = (in_op == OP_GEMM) ? ST_DONE : ST_RUN;
            ST_RUN:   if (step == RUN_LAST) state_nx = ST_DRAIN;
            ST_DRAIN: if (step == DRAIN_LAST) state_nx = ST_DONE;
            ST_DONE:  if (out_ready) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        pe_wc     = '0;
        pe_mac    = '0;
        case (state)
            ST_IDLE:  in_ready = !rst;
            ST_RUN:   begin busy = 1'b1; pe_wc = coef_rd; end
            ST_DRAIN: busy = 1'b1;
            ST_DONE:  out_valid = 1'b1;
            default:  ;
        endcase
        // Cycle 2 seeds the chain with 0; from cycle 3 the PE result loops back.
        if (busy && step >= FB_FIRST && step <= FB_LAST) begin
            pe_mac = pe_o;
        end
    end

    assign pe_gemm_uno = op_q;
    assign pe_var      = x_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step     <= '0;
            op_q     <= OP_GEMM;
            x_q      <= '0;
            out_data <= '0;
            out_err  <= 1'b0;
        end else begin
            if (accept) begin
                step <= '0;
                if (in_op == OP_GEMM) begin
                    out_data <= '0;
                    out_err  <= 1'b1;
                end else begin
                    op_q <= in_op;
                    x_q  <= in_x;
                end
            end else if (busy) begin
                step <= step + CNT_BW'(1);
            end
            if (state == ST_DRAIN && step == DRAIN_LAST) begin
                out_data <= pe_o;
                out_err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uno_seq.sv
// Bench for uno_seq: scripted PE output, per-cycle checks of the PE drive and
// a result scoreboard fed at request time and drained by a monitor.
module tb_uno_seq;

    localparam int MUL_BW    = 16;
    localparam int ACC_BW    = 32;
    localparam int NUM_TERMS = 4;
    localparam int IDX_BW    = 2;
    localparam int N         = NUM_TERMS;
    localparam int W         = ACC_BW + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_we;
    logic [1:0]        cfg_op;
    logic [IDX_BW-1:0] cfg_idx;
    logic [MUL_BW-1:0] cfg_data;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_op;
    logic [MUL_BW-1:0] in_x;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_BW-1:0] out_data;
    logic              out_err;
    logic [1:0]        pe_gemm_uno;
    logic [MUL_BW-1:0] pe_var;
    logic [MUL_BW-1:0] pe_wc;
    logic [ACC_BW-1:0] pe_mac;
    logic [ACC_BW-1:0] pe_o;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0]      exp_q[$];          // {err, data}
    logic [MUL_BW-1:0] coef_m[4][N];      // row 0 unused
    logic [1:0]        last_op;

    uno_seq #(
        .MUL_BW(MUL_BW), .ACC_BW(ACC_BW), .NUM_TERMS(NUM_TERMS), .IDX_BW(IDX_BW)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_op(cfg_op), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_x(in_x),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
        .pe_gemm_uno(pe_gemm_uno), .pe_var(pe_var), .pe_wc(pe_wc), .pe_mac(pe_mac),
        .pe_o(pe_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result actual=%0h required=none", out_data);
            end else begin
                e = exp_q.pop_front();
                check("out_data", 64'(out_data), 64'(e[ACC_BW-1:0]));
                check("out_err", 64'(out_err), 64'(e[ACC_BW]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int o = 0; o < 4; o++) for (int i = 0; i < N; i++) coef_m[o][i] = '0;
        last_op = 2'b00;
    endtask

    task automatic cfg_write(input logic [1:0] op, input logic [IDX_BW-1:0] idx,
                             input logic [MUL_BW-1:0] data);
        cfg_we = 1'b1; cfg_op = op; cfg_idx = idx; cfg_data = data;
        tick();
        cfg_we = 1'b0;
        if (op != 2'b00) coef_m[op][idx] = data;
    endtask

    // Issues one request from IDLE and follows it back to IDLE.
    task automatic run_op(input logic [1:0] op, input logic [MUL_BW-1:0] x, input int hold,
                          input bit cfg_at_accept, input bit cfg_in_run,
                          input logic [ACC_BW-1:0] final_po);
        logic [ACC_BW-1:0] script[N+3];
        logic [MUL_BW-1:0] newc;
        logic [ACC_BW-1:0] exp_data;
        logic              exp_err;
        for (int c = 0; c < N + 2; c++) script[c] = $urandom;
        script[N+2] = final_po;
        exp_data = (op == 2'b00) ? '0 : final_po;
        exp_err  = (op == 2'b00);
        exp_q.push_back({exp_err, exp_data});

        newc = 16'($urandom);
        in_valid = 1'b1; in_op = op; in_x = x; pe_o = script[0];
        if (cfg_at_accept) begin
            cfg_we = 1'b1; cfg_op = op; cfg_idx = '0; cfg_data = newc;
        end
        @(negedge clk);
        check("in_ready_accept", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0; in_op = 2'($urandom); in_x = 16'($urandom);
        if (cfg_at_accept) begin
            cfg_we = 1'b0;
            if (op != 2'b00) coef_m[op][0] = newc;
        end

        if (op != 2'b00) begin
            last_op = op;
            for (int c = 1; c <= N + 2; c++) begin
                pe_o = script[c];
                if (c == 2 && cfg_in_run) begin
                    cfg_we = 1'b1; cfg_op = op; cfg_idx = '0; cfg_data = ~coef_m[op][0];
                end
                if (c == 3) cfg_we = 1'b0;
                @(negedge clk);
                check("pe_gemm_uno", 64'(pe_gemm_uno), 64'(op));
                check("pe_var", 64'(pe_var), 64'(x));
                check("pe_wc", 64'(pe_wc), (c <= N) ? 64'(coef_m[op][c-1]) : 64'd0);
                check("pe_mac", 64'(pe_mac), (c >= 3 && c <= N + 1) ? 64'(script[c]) : 64'd0);
                check("busy_handshake", 64'({in_ready, out_valid}), 64'd0);
                tick();
            end
        end

        for (int h = 0; h <= hold; h++) begin
            out_ready = (h == hold);
            pe_o = $urandom;
            @(negedge clk);
            check("done_valid", 64'({out_valid, in_ready}), 64'b10);
            check("done_data_hold", 64'({out_err, out_data}), 64'({exp_err, exp_data}));
            check("done_pe_idle", 64'({pe_wc, pe_mac}), 64'd0);
            check("done_gemm_uno", 64'(pe_gemm_uno), 64'(last_op));
            tick();
        end
        out_ready = 1'b0;
        @(negedge clk);
        check("release_state", 64'({out_valid, in_ready}), 64'b01);
        tick();
    endtask

    task automatic check_all_zero(input string name);
        check(name, 64'({in_ready, out_valid, out_err, pe_gemm_uno}), 64'd0);
        check({name, "_data"}, 64'(out_data), 64'd0);
        check({name, "_pe"}, 64'({pe_var, pe_wc}), 64'd0);
        check({name, "_mac"}, 64'(pe_mac), 64'd0);
    endtask

    task automatic reset_mid_op();
        in_valid = 1'b1; in_op = 2'b10; in_x = 16'($urandom); pe_o = $urandom;
        @(negedge clk);
        tick();                      // cycle 1
        in_valid = 1'b0;
        tick();                      // cycle 2
        tick();                      // cycle 3
        pe_o = $urandom;
        rst = 1'b1;
        #1;
        check_all_zero("reset_mid_op");
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
        @(negedge clk);
        check("in_ready_after_reset", 64'(in_ready), 64'd1);
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_op = '0; cfg_idx = '0; cfg_data = '0;
        in_valid = 1'b0; in_op = '0; in_x = '0; out_ready = 1'b0; pe_o = '0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_idle", 64'(in_ready), 64'd1);
        tick();

        // Directed: exp with coefficients {3,-2,5,7}, x=4, held result.
        cfg_write(2'b10, 2'd0, 16'd3);
        cfg_write(2'b10, 2'd1, 16'hFFFE);
        cfg_write(2'b10, 2'd2, 16'd5);
        cfg_write(2'b10, 2'd3, 16'd7);
        run_op(2'b10, 16'd4, 5, 1'b0, 1'b0, 32'h0000_1234);

        // Directed: op 00 gives an immediate error result.
        run_op(2'b00, 16'd9, 2, 1'b0, 1'b0, 32'h0);

        // Directed: div write during RUN is dropped.
        for (int i = 0; i < N; i++) cfg_write(2'b01, IDX_BW'(i), 16'($urandom));
        run_op(2'b01, 16'($urandom), 0, 1'b0, 1'b1, $urandom);
        run_op(2'b01, 16'($urandom), 1, 1'b0, 1'b0, $urandom);

        // Directed: write coinciding with accept is seen by the op; op-00 write ignored.
        run_op(2'b11, 16'($urandom), 0, 1'b1, 1'b0, $urandom);
        cfg_write(2'b00, 2'd1, 16'($urandom));
        run_op(2'b11, 16'hFFFF, 0, 1'b0, 1'b0, $urandom);

        // Directed: reset in cycle 3 aborts and clears the table.
        reset_mid_op();
        run_op(2'b10, 16'($urandom), 0, 1'b0, 1'b0, $urandom);

        // Random traffic.
        for (int t = 0; t < 40; t++) begin
            int nw;
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++) begin
                cfg_write(2'($urandom_range(0, 3)), IDX_BW'($urandom_range(0, N - 1)),
                          16'($urandom));
            end
            run_op(2'($urandom_range(0, 3)), 16'($urandom), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
        end

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
